reset_req_arb: RTL and testbench

- Collects reset requests from several on-board requesters: host SPI command, watchdog, front-panel button and VPX backplane.
- Arbitrates them by severity (POR > full > hard > soft) and then by source index.
- Drives exactly one active-low request at a time into the DSP reset sequencer, holding it for a fixed width.
- Tracks completion of the resulting reset via the DSP RESETSTATz status, records the cause, and flags timeouts.
- Sits between the requester logic and the reset sequencer in the SP3AN control FPGA.

---
 rtl/reset_req_arb_pkg.sv | 32 +++
 rtl/reset_req_prio.sv | 29 ++
 rtl/reset_req_arb.sv | 190 +++++++++++++++++++
 tb/tb_reset_req_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_req_arb_pkg.sv
// Shared type codes, FSM encodings and default timing for the reset request arbiter.
package reset_req_arb_pkg;

    typedef enum logic [1:0] {
        T_POR  = 2'd0,
        T_FULL = 2'd1,
        T_HARD = 2'd2,
        T_SOFT = 2'd3
    } rst_type_e;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARB        = 3'd1,
        S_ASSERT     = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_GUARD      = 3'd5
    } state_e;

    localparam int CNT_W = 24;

    localparam logic [CNT_W-1:0] DEF_REQ_HOLD  = 24'd1000;
    localparam logic [CNT_W-1:0] DEF_START_TMO = 24'd100000;
    localparam logic [CNT_W-1:0] DEF_DONE_TMO  = 24'd5000000;
    localparam logic [CNT_W-1:0] DEF_GUARD     = 24'd2000;

    // Active-low request lines ordered {por, full, hard, soft}.
    function automatic logic [3:0] req_lines_n(input logic [1:0] t);
        return ~(4'b1000 >> t);
    endfunction

endpackage

// File: rtl/reset_req_prio.sv
// Combinational arbiter: lowest type code wins, ties resolved towards the lowest index.
module reset_req_prio
    import reset_req_arb_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int SRCW = 2
) (
    input  logic [NSRC-1:0]   pend,
    input  logic [2*NSRC-1:0] types,
    output logic [SRCW-1:0]   grant_src,
    output logic [1:0]        grant_type,
    output logic              any_pend
);

    // Strict less-than keeps the earlier (lower) index on equal severity.
    always_comb begin
        grant_src  = '0;
        grant_type = T_SOFT;
        any_pend   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (pend[i] && (!any_pend || (types[2*i +: 2] < grant_type))) begin
                any_pend   = 1'b1;
                grant_src  = SRCW'(i);
                grant_type = types[2*i +: 2];
            end
        end
    end

endmodule

// File: rtl/reset_req_arb.sv
// Collects reset requests, grants one at a time by severity and tracks DSP reset completion.
module reset_req_arb
    import reset_req_arb_pkg::*;
#(
    parameter int               NSRC      = 4,
    parameter int               SRCW      = 2,
    parameter logic [CNT_W-1:0] REQ_HOLD  = DEF_REQ_HOLD,
    parameter logic [CNT_W-1:0] START_TMO = DEF_START_TMO,
    parameter logic [CNT_W-1:0] DONE_TMO  = DEF_DONE_TMO,
    parameter logic [CNT_W-1:0] GUARD     = DEF_GUARD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC-1:0]   src_req,
    input  logic [2*NSRC-1:0] src_type,
    input  logic [NSRC-1:0]   src_en,
    input  logic              cs_resetstat_n,
    output logic              por_req_n,
    output logic              resetfull_req_n,
    output logic              hreset_req_n,
    output logic              sreset_req_n,
    output logic              busy,
    output logic [NSRC-1:0]   pend,
    output logic [SRCW-1:0]   last_src,
    output logic [1:0]        last_type,
    output logic              cause_valid,
    output logic              timeout_err
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [NSRC-1:0]   pend_q, pend_d;
    logic [2*NSRC-1:0] ptype_q, ptype_d;
    logic [SRCW-1:0]   last_src_q, last_src_d;
    logic [1:0]        last_type_q, last_type_d;
    logic              cause_valid_q, cause_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic              busy_q, busy_d;
    logic [3:0]        req_n_q, req_n_d;
    logic              rs_meta_q, rs_q;
    logic              grant_clr;
    logic [SRCW-1:0]   grant_src;
    logic [1:0]        grant_type;
    logic              any_pend;

    reset_req_prio #(
        .NSRC (NSRC),
        .SRCW (SRCW)
    ) u_prio (
        .pend       (pend_q),
        .types      (ptype_q),
        .grant_src  (grant_src),
        .grant_type (grant_type),
        .any_pend   (any_pend)
    );

    // Resets high so a missing DSP status never looks like a reset already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta_q <= 1'b1;
            rs_q      <= 1'b1;
        end else begin
            rs_meta_q <= cs_resetstat_n;
            rs_q      <= rs_meta_q;
        end
    end

    // A fresh request on the source being granted re-arms it with its own type.
    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        for (int i = 0; i < NSRC; i++) begin
            if (src_req[i] && src_en[i]) begin
                pend_d[i] = 1'b1;
                if (pend_q[i] && !(grant_clr && (grant_src == SRCW'(i)))
                    && (ptype_q[2*i +: 2] < src_type[2*i +: 2]))
                    ptype_d[2*i +: 2] = ptype_q[2*i +: 2];
                else
                    ptype_d[2*i +: 2] = src_type[2*i +: 2];
            end else if (grant_clr && (grant_src == SRCW'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_inc;
        last_src_d    = last_src_q;
        last_type_d   = last_type_q;
        cause_valid_d = cause_valid_q;
        timeout_err_d = timeout_err_q;
        busy_d        = busy_q;
        grant_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (any_pend) state_d = S_ARB;
            end
            S_ARB: begin
                last_src_d    = grant_src;
                last_type_d   = grant_type;
                cause_valid_d = 1'b1;
                busy_d        = 1'b1;
                grant_clr     = 1'b1;
                cnt_d         = '0;
                state_d       = S_ASSERT;
            end
            S_ASSERT: begin
                if (cnt_q >= REQ_HOLD - 1'b1) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (!rs_q) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q >= START_TMO) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_GUARD;
                end
            end
            S_WAIT_DONE: begin
                if (rs_q) begin
                    cnt_d   = '0;
                    state_d = S_GUARD;
                end else if (cnt_q >= DONE_TMO) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_GUARD;
                end
            end
            S_GUARD: begin
                if (cnt_q >= GUARD - 1'b1) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // Registered from the next state so the line is low exactly while in ASSERT.
        req_n_d = (state_d == S_ASSERT) ? req_lines_n(last_type_d) : 4'hF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pend_q        <= '0;
            ptype_q       <= '0;
            last_src_q    <= '0;
            last_type_q   <= '0;
            cause_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            req_n_q       <= 4'hF;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            ptype_q       <= ptype_d;
            last_src_q    <= last_src_d;
            last_type_q   <= last_type_d;
            cause_valid_q <= cause_valid_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            req_n_q       <= req_n_d;
        end
    end

    assign por_req_n       = req_n_q[3];
    assign resetfull_req_n = req_n_q[2];
    assign hreset_req_n    = req_n_q[1];
    assign sreset_req_n    = req_n_q[0];
    assign busy            = busy_q;
    assign pend            = pend_q;
    assign last_src        = last_src_q;
    assign last_type       = last_type_q;
    assign cause_valid     = cause_valid_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_reset_req_arb.sv
// Scoreboard bench: stimulus queues expected grants, a monitor checks each grant as it appears.
module tb_reset_req_arb;
    import reset_req_arb_pkg::*;

    localparam int         NSRC = 4;
    localparam int         SRCW = 2;
    localparam logic [23:0] RH  = 24'd8;
    localparam logic [23:0] ST  = 24'd40;
    localparam logic [23:0] DT  = 24'd60;
    localparam logic [23:0] GD  = 24'd10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NSRC-1:0]   src_req = '0;
    logic [2*NSRC-1:0] src_type = '1;
    logic [NSRC-1:0]   src_en = '1;
    logic              cs_resetstat_n = 1'b1;
    logic              por_req_n, resetfull_req_n, hreset_req_n, sreset_req_n;
    logic              busy;
    logic [NSRC-1:0]   pend;
    logic [SRCW-1:0]   last_src;
    logic [1:0]        last_type;
    logic              cause_valid;
    logic              timeout_err;

    reset_req_arb #(
        .NSRC      (NSRC),
        .SRCW      (SRCW),
        .REQ_HOLD  (RH),
        .START_TMO (ST),
        .DONE_TMO  (DT),
        .GUARD     (GD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_req         (src_req),
        .src_type        (src_type),
        .src_en          (src_en),
        .cs_resetstat_n  (cs_resetstat_n),
        .por_req_n       (por_req_n),
        .resetfull_req_n (resetfull_req_n),
        .hreset_req_n    (hreset_req_n),
        .sreset_req_n    (sreset_req_n),
        .busy            (busy),
        .pend            (pend),
        .last_src        (last_src),
        .last_type       (last_type),
        .cause_valid     (cause_valid),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] typ;
        logic [1:0] src;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endfunction

    function automatic logic any_req_low();
        return !(por_req_n && resetfull_req_n && hreset_req_n && sreset_req_n);
    endfunction

    function automatic void expectGrant(input logic [1:0] typ, input logic [1:0] src);
        exp_t e;
        e.typ = typ;
        e.src = src;
        exp_q.push_back(e);
    endfunction

    // One-cycle strobe; types are packed {src3, src2, src1, src0}.
    task automatic applyStimulus(input logic [NSRC-1:0] req, input logic [2*NSRC-1:0] types);
        @(negedge clk);
        src_req  = req;
        src_type = types;
        @(negedge clk);
        src_req  = '0;
    endtask

    task automatic waitGrant(input string tag);
        logic seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (any_req_low()) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_grant_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic waitRelease(input string tag);
        logic done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!any_req_low()) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_released"}, 32'(done), 32'd1);
    endtask

    task automatic pulseRs(input int low_cycles);
        @(negedge clk);
        cs_resetstat_n = 1'b0;
        repeat (low_cycles) @(negedge clk);
        cs_resetstat_n = 1'b1;
    endtask

    task automatic serveReset(input string tag, input int low_cycles);
        waitGrant(tag);
        waitRelease(tag);
        pulseRs(low_cycles);
    endtask

    task automatic waitIdle(input string tag, output int cycles);
        cycles = 0;
        while (busy && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Monitor: pops an expectation at each grant start and checks hold width at release.
    initial begin : monitor
        logic       active;
        int         hold;
        logic [3:0] lv, cur;
        exp_t       e;
        active = 1'b0;
        hold   = 0;
        cur    = '0;
        forever begin
            @(negedge clk);
            lv = ~{por_req_n, resetfull_req_n, hreset_req_n, sreset_req_n};
            if (!rst_n) begin
                active = 1'b0;
            end else if (!active && lv != 4'h0) begin
                active = 1'b1;
                hold   = 1;
                cur    = lv;
                checkOutput("one_req_low", 32'($countones(lv)), 32'd1);
                checkOutput("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("grant_line", 32'(lv), 32'(4'b1000 >> e.typ));
                    checkOutput("grant_last_src", 32'(last_src), 32'(e.src));
                    checkOutput("grant_last_type", 32'(last_type), 32'(e.typ));
                end
            end else if (active && lv != 4'h0) begin
                hold++;
                checkOutput("line_stable", 32'(lv), 32'(cur));
            end else if (active) begin
                active = 1'b0;
                checkOutput("hold_width", 32'(hold), 32'(RH));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int cyc;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        checkOutput("rst_req_n", 32'({por_req_n, resetfull_req_n, hreset_req_n, sreset_req_n}), 32'hF);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_pend", 32'(pend), 32'd0);
        checkOutput("rst_last", 32'({last_src, last_type}), 32'd0);
        checkOutput("rst_cause_tmo", 32'({cause_valid, timeout_err}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single soft request from source 2.
        expectGrant(2'd3, 2'd2);
        applyStimulus(4'b0100, 8'b11_11_11_11);
        serveReset("soft", 50);
        waitIdle("soft", cyc);
        checkOutput("soft_guard_len_ok", 32'((cyc >= int'(GD)) && (cyc <= int'(GD) + 4)), 32'd1);
        checkOutput("soft_last_src", 32'(last_src), 32'd2);
        checkOutput("soft_last_type", 32'(last_type), 32'd3);
        checkOutput("soft_cause_valid", 32'(cause_valid), 32'd1);
        checkOutput("soft_no_timeout", 32'(timeout_err), 32'd0);

        // Simultaneous: src0 hard and src3 POR; POR must go first.
        expectGrant(2'd0, 2'd3);
        expectGrant(2'd2, 2'd0);
        applyStimulus(4'b1001, 8'b00_11_11_10);
        waitGrant("sim1");
        checkOutput("sim_pend_src0", 32'(pend), 32'b0001);
        waitRelease("sim1");
        pulseRs(5);
        serveReset("sim2", 5);
        waitIdle("sim", cyc);

        // Severity upgrade while pending behind another grant.
        expectGrant(2'd2, 2'd2);
        applyStimulus(4'b0110, 8'b11_10_11_11);
        waitGrant("upg1");
        expectGrant(2'd1, 2'd1);
        applyStimulus(4'b0010, 8'b11_11_01_11);
        checkOutput("upg_pend_src1", 32'(pend), 32'b0010);
        waitRelease("upg1");
        pulseRs(5);
        serveReset("upg2", 5);
        waitIdle("upg", cyc);
        checkOutput("upg_last_type", 32'(last_type), 32'd1);

        // Start timeout: RESETSTATz never drops.
        expectGrant(2'd3, 2'd0);
        applyStimulus(4'b0001, 8'b11_11_11_11);
        waitGrant("tmo");
        waitRelease("tmo");
        checkOutput("tmo_not_yet", 32'(timeout_err), 32'd0);
        waitIdle("tmo", cyc);
        checkOutput("tmo_flag", 32'(timeout_err), 32'd1);
        expectGrant(2'd2, 2'd3);
        applyStimulus(4'b1000, 8'b10_11_11_11);
        serveReset("post_tmo", 5);
        waitIdle("post_tmo", cyc);
        checkOutput("post_tmo_last_src", 32'(last_src), 32'd3);
        checkOutput("post_tmo_sticky", 32'(timeout_err), 32'd1);

        // Masked source must be ignored entirely.
        src_en = 4'b1101;
        applyStimulus(4'b0010, 8'b11_11_00_11);
        repeat (5) @(negedge clk);
        checkOutput("mask_pend", 32'(pend), 32'd0);
        checkOutput("mask_busy", 32'(busy), 32'd0);
        src_en = 4'b1111;

        // Asynchronous reset in the middle of ASSERT.
        expectGrant(2'd2, 2'd0);
        applyStimulus(4'b0001, 8'b11_11_11_10);
        waitGrant("mid");
        checkOutput("mid_hreset_low", 32'(hreset_req_n), 32'd0);
        applyStimulus(4'b1000, 8'b11_11_11_11);
        checkOutput("mid_pend_before", 32'(pend), 32'b1000);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_hreset_high", 32'(hreset_req_n), 32'd1);
        checkOutput("mid_pend_clear", 32'(pend), 32'd0);
        checkOutput("mid_cause_clear", 32'(cause_valid), 32'd0);
        checkOutput("mid_busy_clear", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post_rst_idle_req", 32'({por_req_n, resetfull_req_n, hreset_req_n, sreset_req_n}), 32'hF);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_pend", 32'(pend), 32'd0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
